// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register map, STATUS layout and shifter states.
package uart_pkg;

    // Register offsets decoded from bus_addr[1:0]
    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_DIVISOR  = 2'd2;
    localparam logic [1:0] REG_RESERVED = 2'd3;

    // STATUS bit positions
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_MSB = 15;

    // Number of data bits carried by one frame
    localparam int DATA_BITS = 8;

    // Serial shifter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Assemble the STATUS word from its individual flags and the FIFO fill level
    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       overflow,
        input logic [7:0] count
    );
        logic [31:0] word;
        word                                = 32'd0;
        word[STAT_FULL]                     = full;
        word[STAT_EMPTY]                    = empty;
        word[STAT_BUSY]                     = busy;
        word[STAT_OVERFLOW]                 = overflow;
        word[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged on the current count, so a push into a full FIFO is lost even if a pop happens alongside it
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers define what is valid
    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Bus-attached UART transmitter: TX FIFO, programmable bit period, 8N1 serial shifter.
module uart_tx
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic [29:0] bus_addr,
    input  logic [31:0] bus_data_w,
    input  logic [3:0]  bus_mask_w,
    output logic [31:0] bus_data_r,
    output logic        tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       reg_sel;
    logic             push_req;
    logic             status_clear;
    logic             div_wr_lo;
    logic             div_wr_hi;
    logic [15:0]      divisor;
    logic             overflow;

    logic             fifo_pop;
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    tx_state_t        state;
    logic [15:0]      div_latched;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             bit_end;
    logic             frame_start;
    logic [31:0]      status_word;
    logic             unused_bits;

    assign unused_bits = ^{bus_addr[29:2], bus_data_w[31:16], bus_mask_w[3:2]};

    // Bus write decode; nothing is written while reset is high
    assign reg_sel      = bus_addr[1:0];
    assign push_req     = bus_sel && !reset && (reg_sel == REG_TXDATA) && bus_mask_w[0];
    assign status_clear = bus_sel && !reset && (reg_sel == REG_STATUS) && bus_mask_w[0]
                          && bus_data_w[STAT_OVERFLOW];
    assign div_wr_lo    = bus_sel && !reset && (reg_sel == REG_DIVISOR) && bus_mask_w[0];
    assign div_wr_hi    = bus_sel && !reset && (reg_sel == REG_DIVISOR) && bus_mask_w[1];

    // A bit period ends when the baud counter reaches the divisor captured for this frame
    assign bit_end = (baud_cnt == div_latched);

    // A new frame is loaded from an idle line, or straight out of a finished stop bit if more data waits
    assign frame_start = !fifo_empty &&
                         ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    assign fifo_pop    = frame_start;

    assign status_word = pack_status(fifo_full, fifo_empty, (state != ST_IDLE), overflow,
                                     8'(fifo_count));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (bus_data_w[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Control registers: sticky overflow flag and byte-writable divisor
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            divisor  <= DIV_RESET;
        end else begin
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (status_clear) begin
                overflow <= 1'b0;
            end
            if (div_wr_lo) begin
                divisor[7:0] <= bus_data_w[7:0];
            end
            if (div_wr_hi) begin
                divisor[15:8] <= bus_data_w[15:8];
            end
        end
    end

    // Serial shifter: start bit, eight data bits LSB first, stop bit, with a registered line output
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            tx          <= 1'b1;
            baud_cnt    <= 16'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            div_latched <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (frame_start) begin
                        state       <= ST_START;
                        tx          <= 1'b0;
                        shift_reg   <= fifo_data;
                        div_latched <= divisor;
                        baud_cnt    <= 16'd0;
                        bit_cnt     <= 3'd0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        tx       <= shift_reg[0];
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        if (frame_start) begin
                            state       <= ST_START;
                            tx          <= 1'b0;
                            shift_reg   <= fifo_data;
                            div_latched <= divisor;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Read port: the addressed register is captured every cycle, independent of bus_sel
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_data_r <= 32'd0;
        end else begin
            case (reg_sel)
                REG_TXDATA:  bus_data_r <= 32'd0;
                REG_STATUS:  bus_data_r <= status_word;
                REG_DIVISOR: bus_data_r <= {16'd0, divisor};
                default:     bus_data_r <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed register tests plus random frames against a frame-level model.
module tb_uart_tx;

    localparam logic [1:0]  A_TXDATA  = 2'd0;
    localparam logic [1:0]  A_STATUS  = 2'd1;
    localparam logic [1:0]  A_DIVISOR = 2'd2;
    localparam logic [1:0]  A_RSVD    = 2'd3;
    localparam logic [31:0] DIV_DEF   = 32'd433;

    logic        clock;
    logic        reset;
    logic        bus_sel;
    logic [29:0] bus_addr;
    logic [31:0] bus_data_w;
    logic [3:0]  bus_mask_w;
    logic [31:0] bus_data_r;
    logic        tx;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    uart_tx dut (
        .clock      (clock),
        .reset      (reset),
        .bus_sel    (bus_sel),
        .bus_addr   (bus_addr),
        .bus_data_w (bus_data_w),
        .bus_mask_w (bus_mask_w),
        .bus_data_r (bus_data_r),
        .tx         (tx)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rising-edge counter used to place expected frames in time
    always @(posedge clock) cycle <= cycle + 1;

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One bus cycle, sampled by the next rising edge; returns on the following falling edge
    task automatic applyStimulus(input logic sel, input logic [1:0] addr,
                                 input logic [31:0] data, input logic [3:0] mask);
        bus_sel    = sel;
        bus_addr   = {28'd0, addr};
        bus_data_w = data;
        bus_mask_w = mask;
        @(negedge clock);
        bus_sel    = 1'b0;
        bus_mask_w = 4'd0;
    endtask

    task automatic readRegister(input logic [1:0] addr, output logic [31:0] data);
        bus_sel    = 1'b0;
        bus_mask_w = 4'd0;
        bus_addr   = {28'd0, addr};
        @(negedge clock);
        data = bus_data_r;
    endtask

    // Reference: a frame is {stop, data, start} sent LSB first, each bit held div+1 cycles,
    // with cycle k of the frame visible on the falling edge after rising edge start+k
    task automatic expectFrameAt(input logic [7:0] data, input int div, input int start,
                                 input int upto, input string tag);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        while (cycle < start) @(negedge clock);
        for (int k = cycle - start; k < upto; k++) begin
            checkOutput($sformatf("%s[%0d]", tag, k), {31'd0, tx},
                        {31'd0, frame[k / (div + 1)]});
            @(negedge clock);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          d;
        int          s;
        int          s0;
        logic        saw_low;

        reset      = 1'b1;
        bus_sel    = 1'b0;
        bus_addr   = 30'd0;
        bus_data_w = 32'd0;
        bus_mask_w = 4'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_rdata", bus_data_r, 32'd0);
        readRegister(A_STATUS, rd);
        checkOutput("reset_status", rd, 32'h0000_0002);
        readRegister(A_DIVISOR, rd);
        checkOutput("reset_divisor", rd, DIV_DEF);
        readRegister(A_TXDATA, rd);
        checkOutput("txdata_reads_zero", rd, 32'd0);

        // Divisor byte lanes are independent
        applyStimulus(1'b1, A_DIVISOR, 32'h0000_ABCD, 4'b0010);
        readRegister(A_DIVISOR, rd);
        checkOutput("divisor_hi_lane", rd, 32'h0000_ABB1);
        applyStimulus(1'b1, A_DIVISOR, 32'h0000_0003, 4'b0011);
        readRegister(A_DIVISOR, rd);
        checkOutput("divisor_write", rd, 32'd3);

        // 0x55 at divisor 3
        applyStimulus(1'b1, A_TXDATA, 32'h0000_0055, 4'b0001);
        s = cycle + 1;
        checkOutput("latency_idle_before", {31'd0, tx}, 32'd1);
        expectFrameAt(8'h55, 3, s, 40, "frame55");
        readRegister(A_STATUS, rd);
        checkOutput("status_after_55", rd, 32'h0000_0002);

        // Random bytes at random short divisors
        for (int i = 0; i < 4; i++) begin
            d  = int'($urandom_range(0, 3));
            b0 = 8'($urandom);
            applyStimulus(1'b1, A_DIVISOR, 32'(d), 4'b0011);
            applyStimulus(1'b1, A_TXDATA, {24'd0, b0}, 4'b0001);
            s = cycle + 1;
            checkOutput($sformatf("rand%0d_latency", i), {31'd0, tx}, 32'd1);
            expectFrameAt(b0, d, s, 10 * (d + 1), $sformatf("rand%0d_d%0d_%02h", i, d, b0));
        end

        // Burst of nine writes then one more into a full FIFO
        applyStimulus(1'b1, A_DIVISOR, 32'd3, 4'b0011);
        applyStimulus(1'b1, A_TXDATA, 32'd0, 4'b0001);
        s0 = cycle + 1;
        checkOutput("burst_latency", {31'd0, tx}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, A_TXDATA, 32'(i), 4'b0001);
            if (i == 1) checkOutput("burst_first_starts", {31'd0, tx}, 32'd0);
        end
        applyStimulus(1'b1, A_TXDATA, 32'd9, 4'b0001);
        readRegister(A_STATUS, rd);
        checkOutput("status_full_overflow", rd, 32'h0000_080D);
        for (int i = 0; i <= 8; i++) begin
            expectFrameAt(8'(i), 3, s0 + 40 * i, 40, $sformatf("burst%0d", i));
        end
        checkOutput("burst_dropped_byte", {31'd0, tx}, 32'd1);
        readRegister(A_STATUS, rd);
        checkOutput("status_after_burst", rd, 32'h0000_000A);

        // Overflow clears only with bit 3 set
        applyStimulus(1'b1, A_STATUS, 32'h0000_0007, 4'b0001);
        readRegister(A_STATUS, rd);
        checkOutput("status_write_7", rd, 32'h0000_000A);
        applyStimulus(1'b1, A_STATUS, 32'h0000_0008, 4'b0001);
        readRegister(A_STATUS, rd);
        checkOutput("status_write_8", rd, 32'h0000_0002);

        // Divisor change mid-frame applies to the next frame only
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        applyStimulus(1'b1, A_TXDATA, {24'd0, b0}, 4'b0001);
        s = cycle + 1;
        applyStimulus(1'b1, A_TXDATA, {24'd0, b1}, 4'b0001);
        repeat (4) @(negedge clock);
        applyStimulus(1'b1, A_DIVISOR, 32'd0, 4'b0011);
        expectFrameAt(b0, 3, s, 40, "middiv_cur");
        expectFrameAt(b1, 0, s + 40, 10, "middiv_next");
        readRegister(A_STATUS, rd);
        checkOutput("status_after_middiv", rd, 32'h0000_0002);

        // Reset during data bit 4, with another byte queued and a write attempted during reset
        applyStimulus(1'b1, A_DIVISOR, 32'd3, 4'b0011);
        b0 = 8'($urandom) & 8'hEF;
        applyStimulus(1'b1, A_TXDATA, {24'd0, b0}, 4'b0001);
        s = cycle + 1;
        applyStimulus(1'b1, A_TXDATA, 32'h0000_00A5, 4'b0001);
        expectFrameAt(b0, 3, s, 22, "prereset");
        reset      = 1'b1;
        bus_sel    = 1'b1;
        bus_addr   = {28'd0, A_TXDATA};
        bus_data_w = 32'h0000_005A;
        bus_mask_w = 4'b0001;
        @(negedge clock);
        checkOutput("midreset_tx", {31'd0, tx}, 32'd1);
        checkOutput("midreset_rdata", bus_data_r, 32'd0);
        reset      = 1'b0;
        bus_sel    = 1'b0;
        bus_mask_w = 4'd0;
        bus_addr   = {28'd0, A_STATUS};
        @(negedge clock);
        checkOutput("postreset_status", bus_data_r, 32'h0000_0002);
        readRegister(A_DIVISOR, rd);
        checkOutput("postreset_divisor", rd, DIV_DEF);
        saw_low = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        checkOutput("postreset_line_idle", {31'd0, saw_low}, 32'd0);

        // Reserved offset and deselected writes
        applyStimulus(1'b1, A_RSVD, 32'hFFFF_FFFF, 4'b1111);
        readRegister(A_RSVD, rd);
        checkOutput("reserved_reads_zero", rd, 32'd0);
        applyStimulus(1'b0, A_TXDATA, 32'h0000_0033, 4'b0001);
        readRegister(A_STATUS, rd);
        checkOutput("nosel_fifo_unchanged", rd, 32'h0000_0002);
        checkOutput("nosel_line_idle", {31'd0, tx}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
